// File: rtl/div_unit_pkg.sv
// Shared encodings for the multi-cycle divider and the ex-stage decode that drives it.
package div_unit_pkg;

  typedef enum logic [1:0] {
    DIV_FREE   = 2'b00,
    DIV_BYZERO = 2'b01,
    DIV_ON     = 2'b10,
    DIV_END    = 2'b11
  } div_state_e;

  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;
  localparam logic DIV_START            = 1'b1;
  localparam logic DIV_STOP             = 1'b0;

  // ALU operation codes decoded by ex to select this unit.
  localparam logic [7:0] ALUOP_DIV  = 8'b0001_1010;
  localparam logic [7:0] ALUOP_DIVU = 8'b0001_1011;

endpackage

// File: rtl/div_unit.sv
// Multi-cycle restoring divider for DIV/DIVU; result_o = {remainder, quotient}.
// Optional macro DIV_EARLY_OUT_EN: finish at once when |dividend| < |divisor|.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                signed_div_i,
  input  logic [DATA_W-1:0]   opdata1_i,
  input  logic [DATA_W-1:0]   opdata2_i,
  input  logic                start_i,
  input  logic                annul_i,
  output logic [2*DATA_W-1:0] result_o,
  output logic                ready_o
);

  localparam int CNT_W  = $clog2(DATA_W);
  localparam int WORK_W = 2 * DATA_W + 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_W - 1);

  function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W-1:0] v,
                                                  input logic is_signed);
    return (is_signed && v[DATA_W-1]) ? (~v + DATA_W'(1)) : v;
  endfunction

  div_state_e          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [WORK_W-1:0]   work_q, work_d;
  logic [DATA_W-1:0]   divisor_q, divisor_d;
  logic                neg_quot_q, neg_quot_d;
  logic                neg_rem_q, neg_rem_d;
  logic                ready_q, ready_d;
  logic [2*DATA_W-1:0] result_q, result_d;

  logic [DATA_W-1:0]   op1_mag, op2_mag;
  logic                divisor_zero, early_out, accept;
  logic [DATA_W+1:0]   trial, diff;
  logic [WORK_W-1:0]   step_work;
  logic [DATA_W-1:0]   quot_raw, rem_raw;

  // Working reg: partial remainder in the upper DATA_W+1 bits, dividend
  // bits shifting out / quotient bits shifting in at the bottom.
  always_comb begin
    op1_mag      = magnitude(opdata1_i, signed_div_i);
    op2_mag      = magnitude(opdata2_i, signed_div_i);
    divisor_zero = (opdata2_i == '0);
    accept       = (start_i == DIV_START) && !annul_i;
`ifdef DIV_EARLY_OUT_EN
    early_out    = !divisor_zero && (op1_mag < op2_mag);
`else
    early_out    = 1'b0;
`endif
    trial = {work_q[WORK_W-1:DATA_W], work_q[DATA_W-1]};
    diff  = trial - {2'b00, divisor_q};
    if (diff[DATA_W+1]) begin
      step_work = {trial[DATA_W:0], work_q[DATA_W-2:0], 1'b0};
    end else begin
      step_work = {diff[DATA_W:0], work_q[DATA_W-2:0], 1'b1};
    end
    quot_raw = work_q[DATA_W-1:0];
    rem_raw  = work_q[2*DATA_W-1:DATA_W];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= DIV_FREE;
      cnt_q      <= '0;
      work_q     <= '0;
      divisor_q  <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      ready_q    <= DIV_RESULT_NOT_READY;
      result_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      work_q     <= work_d;
      divisor_q  <= divisor_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
      ready_q    <= ready_d;
      result_q   <= result_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    work_d     = work_q;
    divisor_d  = divisor_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    case (state_q)
      DIV_FREE: begin
        if (accept) begin
          divisor_d  = op2_mag;
          neg_quot_d = signed_div_i && (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
          neg_rem_d  = signed_div_i && opdata1_i[DATA_W-1];
          work_d     = {{(DATA_W+1){1'b0}}, op1_mag};
          cnt_d      = '0;
          if (divisor_zero) begin
            state_d = DIV_BYZERO;
          end else if (early_out) begin
            // Quotient 0, remainder is the dividend magnitude; sign fix-up restores it.
            work_d  = {1'b0, op1_mag, {DATA_W{1'b0}}};
            state_d = DIV_END;
          end else begin
            state_d = DIV_ON;
          end
        end
      end
      DIV_BYZERO: begin
        work_d  = '0;
        state_d = annul_i ? DIV_FREE : DIV_END;
      end
      DIV_ON: begin
        if (annul_i) begin
          state_d = DIV_FREE;
        end else begin
          work_d = step_work;
          cnt_d  = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_STEP) begin
            state_d = DIV_END;
          end
        end
      end
      DIV_END: begin
        if (annul_i || start_i == DIV_STOP) begin
          state_d = DIV_FREE;
        end
      end
      default: state_d = DIV_FREE;
    endcase
  end

  always_comb begin
    ready_d  = DIV_RESULT_NOT_READY;
    result_d = '0;
    if (state_q == DIV_END && accept) begin
      ready_d = DIV_RESULT_READY;
      result_d[DATA_W-1:0]        = neg_quot_q ? (~quot_raw + DATA_W'(1)) : quot_raw;
      result_d[2*DATA_W-1:DATA_W] = neg_rem_q  ? (~rem_raw + DATA_W'(1))  : rem_raw;
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;

endmodule
